// File: rtl/matrixmul_sdiv_8s_6s_seq.sv
// Sequential signed divider: one restoring step per enabled clock, ap_ctrl-style start/done.
// Latency din0_WIDTH+1 cycles from accept to ap_done; starts outside IDLE are dropped, ce=0 freezes all.
// Backpressure: none; ap_idle low while busy, caller must hold ap_start until accepted.
module matrixmul_sdiv_8s_6s_seq #(
    parameter int din0_WIDTH = 8,
    parameter int din1_WIDTH = 6,
    parameter int dout_WIDTH = 8,
    parameter int rem_WIDTH  = 6
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ce,
    input  logic                  ap_start,
    output logic                  ap_idle,
    output logic                  ap_done,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic [dout_WIDTH-1:0] quotient,
    output logic [rem_WIDTH-1:0]  remainder
);

    localparam int CW = $clog2(din0_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         cnt;
    logic [din0_WIDTH-1:0] dvd;   // dividend magnitude shifts out, quotient bits shift in
    logic [din1_WIDTH-1:0] dsr;
    logic [din1_WIDTH-1:0] prem;
    logic                  sign0, sign1, dz;

    logic [din0_WIDTH-1:0] abs0;
    logic [din1_WIDTH-1:0] abs1;
    logic [din1_WIDTH:0]   shifted;
    logic                  ge;
    logic [din1_WIDTH-1:0] prem_nxt;
    logic [din0_WIDTH-1:0] dvd_nxt;
    logic                  last_step;
    logic                  q_neg;
    logic [din0_WIDTH-1:0] q_res;
    logic [din1_WIDTH-1:0] r_res;

    // Unsigned W-bit magnitude also covers -2^(W-1), so no extra bit is needed.
    assign abs0 = din0[din0_WIDTH-1] ? (~din0) + din0_WIDTH'(1) : din0;
    assign abs1 = din1[din1_WIDTH-1] ? (~din1) + din1_WIDTH'(1) : din1;

    assign shifted   = {prem, dvd[din0_WIDTH-1]};
    assign ge        = (shifted >= {1'b0, dsr});
    assign prem_nxt  = ge ? din1_WIDTH'(shifted - {1'b0, dsr}) : shifted[din1_WIDTH-1:0];
    assign dvd_nxt   = {dvd[din0_WIDTH-2:0], ge};
    assign last_step = (cnt == CW'(din0_WIDTH - 1));

    // Divide-by-zero quotient is forced; the remainder path naturally yields din0's low bits.
    assign q_neg = (sign0 ^ sign1) && (dvd_nxt != '0);
    assign q_res = dz ? '1 : (q_neg ? -dvd_nxt : dvd_nxt);
    assign r_res = sign0 ? -prem_nxt : prem_nxt;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state <= IDLE;
        end else if (ce) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ap_idle   = 1'b0;
        ap_done   = 1'b0;
        case (state)
            IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) state_nxt = CALC;
            end
            CALC: begin
                if (last_step) state_nxt = DONE;
            end
            DONE: begin
                ap_done   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            cnt       <= '0;
            dvd       <= '0;
            dsr       <= '0;
            prem      <= '0;
            sign0     <= 1'b0;
            sign1     <= 1'b0;
            dz        <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else if (ce) begin
            if (state == IDLE && ap_start) begin
                dvd   <= abs0;
                dsr   <= abs1;
                prem  <= '0;
                sign0 <= din0[din0_WIDTH-1];
                sign1 <= din1[din1_WIDTH-1];
                dz    <= (din1 == '0);
                cnt   <= '0;
            end else if (state == CALC) begin
                dvd  <= dvd_nxt;
                prem <= prem_nxt;
                cnt  <= cnt + CW'(1);
                if (last_step) begin
                    quotient  <= q_res;
                    remainder <= r_res;
                end
            end
        end
    end

endmodule

// File: tb/tb_matrixmul_sdiv_8s_6s_seq.sv
// Randomized and directed bench for the sequential signed divider against an arithmetic model.
module tb_matrixmul_sdiv_8s_6s_seq;

    logic       ap_clk = 1'b0;
    logic       ap_rst, ce, ap_start;
    logic       ap_idle, ap_done;
    logic [7:0] din0, quotient;
    logic [5:0] din1, remainder;

    int checks = 0;
    int errors = 0;
    logic [7:0] prev_q = '0;
    logic [5:0] prev_r = '0;

    always #5 ap_clk = ~ap_clk;

    matrixmul_sdiv_8s_6s_seq dut (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .ce       (ce),
        .ap_start (ap_start),
        .ap_idle  (ap_idle),
        .ap_done  (ap_done),
        .din0     (din0),
        .din1     (din1),
        .quotient (quotient),
        .remainder(remainder)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Plain integer division truncates toward zero; % takes the dividend's sign.
    function automatic void model(input int a, input int b, output logic [7:0] q, output logic [5:0] r);
        int qi, ri;
        if (b == 0) begin
            qi = -1;
            ri = a;
        end else begin
            qi = a / b;
            ri = a % b;
        end
        q = qi[7:0];
        r = ri[5:0];
    endfunction

    // Called at a negedge; returns at a negedge with the DUT idle.
    task automatic do_op(input logic [7:0] a, input logic [5:0] b,
                         input logic [7:0] eq, input logic [5:0] er, input bit toggle);
        int  n, stalls;
        bit  got;
        n = 0;
        while (!ap_idle && n < 50) begin
            @(negedge ap_clk);
            n++;
        end
        check("idle_before", ap_idle, 1);
        ap_start = 1'b1;
        din0     = a;
        din1     = b;
        ce       = 1'b1;
        @(negedge ap_clk);
        ap_start = 1'b0;
        din0     = $urandom;
        din1     = $urandom;
        n        = 1;
        stalls   = 0;
        got      = ap_done;
        check("idle_calc", ap_idle, 0);
        check("hold_q", quotient, prev_q);
        check("hold_r", remainder, prev_r);
        while (!got && n < 200) begin
            if (toggle) begin
                ce = 1'($urandom_range(0, 1));
                if (!ce) stalls++;
            end
            @(negedge ap_clk);
            n++;
            din0 = $urandom;
            din1 = $urandom;
            if (ap_done) got = 1'b1;
        end
        check("done_seen", got, 1);
        check("latency", n, 9 + stalls);
        check("quot", quotient, eq);
        check("rem", remainder, er);
        if (toggle) begin
            ce = 1'b0;
            @(negedge ap_clk);
            check("done_hold_ce0", ap_done, 1);
            ce = 1'b1;
        end
        @(negedge ap_clk);
        check("done_pulse", ap_done, 0);
        check("idle_after", ap_idle, 1);
        prev_q = eq;
        prev_r = er;
    endtask

    task automatic run(input logic [7:0] a, input logic [5:0] b, input bit toggle);
        logic [7:0] eq;
        logic [5:0] er;
        model($signed(a), $signed(b), eq, er);
        do_op(a, b, eq, er, toggle);
    endtask

    // ap_start held high with operands changing every cycle.
    task automatic stream(input int nops);
        logic [7:0] qa[$];
        logic [5:0] qb[$];
        logic [7:0] eq, ta;
        logic [5:0] er, tb;
        int last_acc, cyc, done_cnt;
        last_acc = -1;
        cyc      = 0;
        done_cnt = 0;
        ce       = 1'b1;
        ap_start = 1'b1;
        while (done_cnt < nops && cyc < 500) begin
            din0 = $urandom;
            din1 = $urandom;
            if (ap_idle) begin
                qa.push_back(din0);
                qb.push_back(din1);
                if (last_acc >= 0) check("accept_interval", cyc - last_acc, 10);
                last_acc = cyc;
            end
            @(negedge ap_clk);
            cyc++;
            if (ap_done) begin
                check("stream_queue", qa.size(), 1);
                if (qa.size() > 0) begin
                    ta = qa.pop_front();
                    tb = qb.pop_front();
                    model($signed(ta), $signed(tb), eq, er);
                    check("stream_quot", quotient, eq);
                    check("stream_rem", remainder, er);
                    prev_q = eq;
                    prev_r = er;
                end
                done_cnt++;
            end
        end
        ap_start = 1'b0;
        check("stream_ops", done_cnt, nops);
        @(negedge ap_clk);
        check("stream_idle", ap_idle, 1);
    endtask

    initial begin
        int dones;
        ap_rst   = 1'b1;
        ce       = 1'b0;
        ap_start = 1'b0;
        din0     = '0;
        din1     = '0;
        @(negedge ap_clk);
        check("rst_idle", ap_idle, 1);
        check("rst_done", ap_done, 0);
        check("rst_q", quotient, 0);
        check("rst_r", remainder, 0);
        ap_rst = 1'b0;
        ce     = 1'b1;
        @(negedge ap_clk);

        do_op(8'd100,             6'd7,              8'd14,              6'd2,              1'b0);
        do_op(8'($signed(-100)),  6'd7,              8'($signed(-14)),   6'($signed(-2)),   1'b0);
        do_op(8'd100,             6'($signed(-7)),   8'($signed(-14)),   6'd2,              1'b0);
        do_op(8'($signed(-100)),  6'($signed(-7)),   8'd14,              6'($signed(-2)),   1'b0);
        do_op(8'($signed(-32)),   6'd31,             8'hFF,              6'h3F,             1'b0);
        do_op(8'h80,              6'h3F,             8'h80,              6'd0,              1'b0);
        do_op(8'd5,               6'd0,              8'hFF,              6'd5,              1'b0);
        do_op(8'd0,               6'h20,             8'd0,               6'd0,              1'b0);
        do_op(8'd100,             6'd7,              8'd14,              6'd2,              1'b1);

        stream(4);

        // Reset mid-operation: aborts with no done, outputs cleared asynchronously.
        ap_start = 1'b1;
        din0     = 8'd100;
        din1     = 6'd7;
        @(negedge ap_clk);
        ap_start = 1'b0;
        repeat (3) @(negedge ap_clk);
        ap_rst = 1'b1;
        #1;
        check("arst_idle", ap_idle, 1);
        check("arst_q", quotient, 0);
        check("arst_r", remainder, 0);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        dones  = 0;
        repeat (12) begin
            @(negedge ap_clk);
            if (ap_done) dones++;
        end
        check("arst_no_done", dones, 0);
        prev_q = '0;
        prev_r = '0;
        do_op(8'd27, 6'($signed(-5)), 8'($signed(-5)), 6'd2, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run(8'($urandom), 6'($urandom), 1'(i % 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
